// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//   - op code constants (OP_AND .. OP_MUL)
//   - top-level FSM state type and iterative-unit operation kind
//   - helpers that classify ops as iterative (multi-cycle) or not
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        IT_SLL,
        IT_SRL,
        IT_SRA,
        IT_MUL
    } iter_kind_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // A shift by zero completes on the single-cycle path; MUL is only
    // iterative when the multiplier is built in (otherwise it is undefined).
    function automatic logic is_multicycle(input logic [3:0] op,
                                           input logic       amt_nonzero,
                                           input logic       mul_en);
        return (is_shift(op) && amt_nonzero) || (mul_en && (op == OP_MUL));
    endfunction

    function automatic iter_kind_t iter_kind(input logic [3:0] op);
        iter_kind_t k;
        case (op)
            OP_SLL:  k = IT_SLL;
            OP_SRL:  k = IT_SRL;
            OP_SRA:  k = IT_SRA;
            default: k = IT_MUL;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// alu_iter_unit: iterative shifter / shift-add multiplier.
//   clk, reset  : clock, async active-high reset
//   flush       : abandons the current iteration
//   start       : load operands and begin (ignored while flush is high)
//   kind        : shift direction/type or multiply
//   opa, opb    : operands (opb is the multiplier for MUL)
//   amount      : shift distance (must be non-zero when start is used for a shift)
//   done        : high during the final iteration cycle
//   result_next : value the final iteration produces; valid while done=1
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         start,
    input  iter_kind_t                   kind,
    input  logic [WIDTH-1:0]             opa,
    input  logic [WIDTH-1:0]             opb,
    input  logic [$clog2(WIDTH)-1:0]     amount,
    output logic                         done,
    output logic [WIDTH-1:0]             result_next
);

    localparam int SHW = $clog2(WIDTH);

    logic             busy;
    iter_kind_t       kind_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [SHW:0]     cnt;
    logic [WIDTH-1:0] acc_next;

    // One step of the current operation: shift by one bit, or add the
    // (already aligned) multiplicand when the current multiplier bit is set.
    always_comb begin
        acc_next = acc;
        unique case (kind_q)
            IT_SLL: acc_next = {acc[WIDTH-2:0], 1'b0};
            IT_SRL: acc_next = {1'b0, acc[WIDTH-1:1]};
            IT_SRA: acc_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
            IT_MUL: acc_next = mplier[0] ? (acc + mcand) : acc;
        endcase
    end

    // The top captures result_next on the edge that ends the last iteration,
    // so done is asserted while the final step is still combinational.
    assign done        = busy && (cnt == (SHW+1)'(1));
    assign result_next = acc_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy   <= 1'b0;
            kind_q <= IT_SLL;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (flush) begin
            busy <= 1'b0;
        end else if (start) begin
            busy   <= 1'b1;
            kind_q <= kind;
            mcand  <= opa;
            mplier <= opb;
            if (kind == IT_MUL) begin
                acc <= '0;
                cnt <= (SHW+1)'(WIDTH);
            end else begin
                acc <= opa;
                cnt <= {1'b0, amount};
            end
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= {mcand[WIDTH-2:0], 1'b0};
            mplier <= {1'b0, mplier[WIDTH-1:1]};
            cnt    <= cnt - (SHW+1)'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes and status flags.
//   clk, reset           : clock, async active-high reset
//   flush                : synchronous abort of in-flight op / pending result
//   in_valid, in_ready   : op handshake (in_ready only in IDLE)
//   op, source1, source2 : op code and operands (shift amount in source2[SHW-1:0])
//   out_valid, out_ready : result handshake; result/flags held while out_valid
//   result               : operation result
//   carry_out            : ADD carry / SUB borrow, else 0
//   overflow             : ADD/SUB signed overflow, else 0
//   zero, negative       : result == 0, result MSB
// Parameters: WIDTH (power of two, 8..64), MUL_EN (0 makes MUL undefined).
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] source1,
    input  logic [WIDTH-1:0] source2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    logic [SHW-1:0]   amount;
    logic             multi;
    logic             start;
    logic             iter_done;
    logic [WIDTH-1:0] iter_result;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry;
    logic             sc_ovf;

    assign amount = source2[SHW-1:0];
    assign multi  = is_multicycle(op, |amount, MUL_EN);
    assign start  = (state == ST_IDLE) && in_valid && !flush && multi;

    alu_iter_unit #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .start       (start),
        .kind        (iter_kind(op)),
        .opa         (source1),
        .opb         (source2),
        .amount      (amount),
        .done        (iter_done),
        .result_next (iter_result)
    );

    // Subtraction as A + ~B + 1: the extra MSB is the "no borrow" carry.
    assign sum  = {1'b0, source1} + {1'b0, source2};
    assign diff = {1'b0, source1} + {1'b0, ~source2} + (WIDTH+1)'(1);

    // Single-cycle datapath, evaluated on the raw inputs and captured at accept.
    // Shifts only reach this path with a zero amount, so they pass source1.
    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        case (op)
            OP_AND: sc_res = source1 & source2;
            OP_OR:  sc_res = source1 | source2;
            OP_XOR: sc_res = source1 ^ source2;
            OP_ADD: begin
                sc_res   = sum[WIDTH-1:0];
                sc_carry = sum[WIDTH];
                sc_ovf   = (source1[WIDTH-1] == source2[WIDTH-1]) &&
                           (sum[WIDTH-1] != source1[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res   = diff[WIDTH-1:0];
                sc_carry = ~diff[WIDTH];
                sc_ovf   = (source1[WIDTH-1] != source2[WIDTH-1]) &&
                           (diff[WIDTH-1] != source1[WIDTH-1]);
            end
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(source1) < $signed(source2))};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (source1 < source2)};
            OP_SLL, OP_SRL, OP_SRA: sc_res = source1;
            default: sc_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else if (flush) begin
            // Result and flags are left as-is; only the handshake is cleared.
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (multi) begin
                            state <= ST_BUSY;
                        end else begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            result    <= sc_res;
                            carry_out <= sc_carry;
                            overflow  <= sc_ovf;
                            zero      <= (sc_res == '0);
                            negative  <= sc_res[WIDTH-1];
                        end
                    end
                end
                ST_BUSY: begin
                    if (iter_done) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        result    <= iter_result;
                        carry_out <= 1'b0;
                        overflow  <= 1'b0;
                        zero      <= (iter_result == '0);
                        negative  <= iter_result[WIDTH-1];
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
